cv32e40x_ex_inorder_collector: RTL and testbench

- Parametrised successor to the fixed EX-stage functional-unit muxing.
- Issues ID-stage operations to one of NUM_UNITS multi-cycle functional-unit channels (ALU, MUL, DIV, custom) over valid/ready handshakes.
- Tracks up to DEPTH outstanding operations in a circular in-order buffer and retires completed results to WB strictly in program order.
- Sits between the ID/EX pipe and the WB stage; honours controller kill/halt.

---
 rtl/cv32e40x_ex_inorder_collector.sv | 145 ++++++++++++++
 tb/tb_cv32e40x_ex_inorder_collector.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_ex_inorder_collector.sv
`default_nettype none
// ============================================================================
// cv32e40x_ex_inorder_collector - issues ID ops to NUM_UNITS FU channels and
// retires their results to WB strictly in program order.
// Optional: CV32E40X_EX_COLLECT_BYPASS_EN forwards a head completion to WB.
// Rev 1.0
// ============================================================================
module cv32e40x_ex_inorder_collector #(
  parameter int XLEN      = 32,
  parameter int NUM_UNITS = 4,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 5,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid_i,
  output logic                      id_ready_o,
  input  logic [NUM_UNITS-1:0]      id_unit_i,
  input  logic [XLEN-1:0]           id_op_a_i,
  input  logic [XLEN-1:0]           id_op_b_i,
  input  logic                      id_rf_we_i,
  input  logic [ADDR_W-1:0]         id_rf_waddr_i,
  output logic [NUM_UNITS-1:0]      unit_valid_o,
  input  logic [NUM_UNITS-1:0]      unit_ready_i,
  output logic [XLEN-1:0]           unit_op_a_o,
  output logic [XLEN-1:0]           unit_op_b_o,
  input  logic [NUM_UNITS-1:0]      unit_rvalid_i,
  output logic [NUM_UNITS-1:0]      unit_rready_o,
  input  logic [NUM_UNITS*XLEN-1:0] unit_rdata_i,
  output logic                      unit_kill_o,
  input  logic                      kill_i,
  input  logic                      halt_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic                      wb_rf_we_o,
  output logic [ADDR_W-1:0]         wb_rf_waddr_o,
  output logic [XLEN-1:0]           wb_rf_wdata_o,
  output logic [CNT_W-1:0]          count_o,
  output logic                      empty_o
);

  logic [NUM_UNITS-1:0] ent_unit  [DEPTH];
  logic                 ent_we    [DEPTH];
  logic [ADDR_W-1:0]    ent_waddr [DEPTH];
  logic                 ent_done  [DEPTH];
  logic [XLEN-1:0]      ent_data  [DEPTH];

  logic [PTR_W-1:0] alloc_ptr, cmpl_ptr, head_ptr;
  logic [CNT_W-1:0] count;
  // pend_cnt: entries allocated but not yet passed by cmpl_ptr
  logic [CNT_W-1:0] pend_cnt;

  logic            full, blocked, unit_hit, issue;
  logic            cmpl_busy, cmpl_fire, cmpl_adv, bypass, retire;
  logic [XLEN-1:0] cmpl_data;

  // Issue side
  assign full        = (count == CNT_W'(DEPTH));
  assign blocked     = full | halt_i | kill_i;
  assign unit_hit    = (id_unit_i == '0) | (|(id_unit_i & unit_ready_i));
  assign id_ready_o  = !blocked & unit_hit;
  assign unit_valid_o = {NUM_UNITS{id_valid_i & !blocked}} & id_unit_i;
  assign unit_op_a_o = id_op_a_i;
  assign unit_op_b_o = id_op_b_i;
  assign unit_kill_o = kill_i;
  assign issue       = id_valid_i & id_ready_o;

  // Completion only listens to the unit owning the oldest not-done entry
  assign cmpl_busy     = (pend_cnt != '0);
  assign unit_rready_o = {NUM_UNITS{cmpl_busy & !ent_done[cmpl_ptr]}} & ent_unit[cmpl_ptr];
  assign cmpl_fire     = |(unit_rvalid_i & unit_rready_o);
  assign cmpl_adv      = cmpl_busy & (ent_done[cmpl_ptr] | cmpl_fire);

  always_comb begin
    cmpl_data = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (unit_rready_o[i]) cmpl_data = cmpl_data | unit_rdata_i[i*XLEN +: XLEN];
    end
  end

`ifdef CV32E40X_EX_COLLECT_BYPASS_EN
  assign bypass = cmpl_fire & (cmpl_ptr == head_ptr);
`else
  assign bypass = 1'b0;
`endif

  // Retire side
  assign wb_valid_o    = !kill_i & (count != '0) & (ent_done[head_ptr] | bypass);
  assign wb_rf_we_o    = ent_we[head_ptr];
  assign wb_rf_waddr_o = ent_waddr[head_ptr];
  assign wb_rf_wdata_o = bypass ? cmpl_data : ent_data[head_ptr];
  assign retire        = wb_valid_o & wb_ready_i;
  assign count_o       = count;
  assign empty_o       = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      cmpl_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pend_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_unit[i]  <= '0;
        ent_we[i]    <= 1'b0;
        ent_waddr[i] <= '0;
        ent_done[i]  <= 1'b0;
        ent_data[i]  <= '0;
      end
    end else if (kill_i) begin
      alloc_ptr <= '0;
      cmpl_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pend_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_done[i] <= 1'b0;
    end else begin
      // Index conflicts are impossible: issue never targets a live slot, and
      // a completing entry is never done so it cannot be retiring from storage.
      if (issue) begin
        ent_unit[alloc_ptr]  <= id_unit_i;
        ent_we[alloc_ptr]    <= id_rf_we_i;
        ent_waddr[alloc_ptr] <= id_rf_waddr_i;
        ent_done[alloc_ptr]  <= (id_unit_i == '0);
        ent_data[alloc_ptr]  <= '0;
        alloc_ptr            <= alloc_ptr + PTR_W'(1);
      end
      if (cmpl_fire && !(bypass && wb_ready_i)) begin
        ent_data[cmpl_ptr] <= cmpl_data;
        ent_done[cmpl_ptr] <= 1'b1;
      end
      if (retire) begin
        ent_done[head_ptr] <= 1'b0;
        head_ptr           <= head_ptr + PTR_W'(1);
      end
      if (cmpl_adv) cmpl_ptr <= cmpl_ptr + PTR_W'(1);
      count    <= count + CNT_W'(issue) - CNT_W'(retire);
      pend_cnt <= pend_cnt + CNT_W'(issue) - CNT_W'(cmpl_adv);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_ex_inorder_collector.sv
`default_nettype none
// Bench for cv32e40x_ex_inorder_collector: directed scenarios then random traffic,
// checked against a program-order transaction model and behavioural FU models.
module tb_cv32e40x_ex_inorder_collector;
  localparam int XLEN = 32, NU = 4, DEPTH = 4, AW = 5, CW = 3;
`ifdef CV32E40X_EX_COLLECT_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid_i = 1'b0, id_ready_o, id_rf_we_i = 1'b0;
  logic [NU-1:0] id_unit_i = '0, unit_valid_o, unit_ready_i = '0, unit_rvalid_i = '0, unit_rready_o;
  logic [XLEN-1:0] id_op_a_i = '0, id_op_b_i = '0, unit_op_a_o, unit_op_b_o, wb_rf_wdata_o;
  logic [AW-1:0] id_rf_waddr_i = '0, wb_rf_waddr_o;
  logic [NU*XLEN-1:0] unit_rdata_i = '0;
  logic unit_kill_o, kill_i = 1'b0, halt_i = 1'b0, wb_valid_o, wb_ready_i = 1'b0, wb_rf_we_o, empty_o;
  logic [CW-1:0] count_o;

  always #5 clk = ~clk;

  cv32e40x_ex_inorder_collector #(.XLEN(XLEN), .NUM_UNITS(NU), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_unit_i(id_unit_i),
    .id_op_a_i(id_op_a_i), .id_op_b_i(id_op_b_i), .id_rf_we_i(id_rf_we_i), .id_rf_waddr_i(id_rf_waddr_i),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i), .unit_op_a_o(unit_op_a_o),
    .unit_op_b_o(unit_op_b_o), .unit_rvalid_i(unit_rvalid_i), .unit_rready_o(unit_rready_o),
    .unit_rdata_i(unit_rdata_i), .unit_kill_o(unit_kill_o), .kill_i(kill_i), .halt_i(halt_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rf_we_o(wb_rf_we_o),
    .wb_rf_waddr_o(wb_rf_waddr_o), .wb_rf_wdata_o(wb_rf_wdata_o), .count_o(count_o), .empty_o(empty_o));

  // Program-order model: one record per accepted op until it is retired
  typedef struct { logic [NU-1:0] unit; logic we; logic [AW-1:0] waddr; logic [XLEN-1:0] data; bit cmpl; int rdy; } ent_t;
  typedef struct { int idx; logic [XLEN-1:0] res; } job_t;
  ent_t oq[$];
  job_t uq[$];
  logic [XLEN-1:0] wb_log[$];

  int n_cmp = 0, n_err = 0, cyc = 0;
  bit rv_rand = 0;
  logic [NU-1:0] rv_en = '0, stale_rv = '0;
  logic last_wbv, last_ir, last_uk;
  logic [NU-1:0] last_rr, last_uv;
  logic [XLEN-1:0] last_wdata;
  int last_wb_cyc = -1;

  function automatic logic [XLEN-1:0] f(logic [XLEN-1:0] a, logic [XLEN-1:0] b, int idx);
    return a + b + ((idx == 1) ? '0 : (XLEN'(idx) << 24));
  endfunction

  function automatic int oh2idx(logic [NU-1:0] v);
    for (int i = 0; i < NU; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_id(logic v, logic [NU-1:0] u, logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic we, logic [AW-1:0] wa);
    id_valid_i = v; id_unit_i = u; id_op_a_i = a; id_op_b_i = b; id_rf_we_i = we; id_rf_waddr_i = wa;
  endtask

  // Behavioural functional units: FIFO of results per unit, offered over rvalid
  task automatic drive_units();
    logic [NU-1:0] rv;
    logic [NU*XLEN-1:0] rd;
    int j;
    rv = '0;
    rd = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < NU; i++) begin
      j = -1;
      foreach (uq[q]) if (j < 0 && uq[q].idx == i) j = q;
      if (j >= 0) begin
        rd[i*XLEN +: XLEN] = uq[j].res;
        rv[i] = rv_rand ? ($urandom_range(0, 2) != 0) : rv_en[i];
      end
      if (stale_rv[i]) begin
        rv[i] = 1'b1;
        rd[i*XLEN +: XLEN] = 32'hdead_beef;
      end
    end
    unit_rvalid_i = rv;
    unit_rdata_i  = rd;
  endtask

  task automatic step();
    logic [NU-1:0] fire, exp_uv;
    bit room, exp_rdy, exp_wbv;
    int k, j, fi;
    drive_units();
    @(negedge clk);
    last_wbv = wb_valid_o; last_ir = id_ready_o; last_uk = unit_kill_o;
    last_rr = unit_rready_o; last_uv = unit_valid_o; last_wdata = wb_rf_wdata_o;
    chk("count", 64'(count_o), 64'(oq.size()));
    chk("empty", 64'(empty_o), 64'(oq.size() == 0));
    room = oq.size() < DEPTH;
    exp_rdy = room && !halt_i && !kill_i && (id_unit_i == '0 || (id_unit_i & unit_ready_i) != '0);
    chk("id_ready", 64'(id_ready_o), 64'(exp_rdy));
    exp_uv = (id_valid_i && room && !halt_i && !kill_i) ? id_unit_i : '0;
    chk("unit_valid", 64'(unit_valid_o), 64'(exp_uv));
    chk("unit_kill", 64'(unit_kill_o), 64'(kill_i));
    k = -1;
    foreach (oq[q]) if (k < 0 && !oq[q].cmpl) k = q;
    if (k < 0) chk("rready_idle", 64'(unit_rready_o), 64'(0));
    else chk("rready_order", 64'(unit_rready_o == '0 || unit_rready_o == oq[k].unit), 64'(1));
    fire = unit_rvalid_i & unit_rready_o;
    if (!kill_i && fire != '0) begin
      if (k < 0) chk("stale_accept", 64'(fire), 64'(0));
      else begin
        chk("cmpl_unit", 64'(fire), 64'(oq[k].unit));
        oq[k].cmpl = 1;
        oq[k].rdy = cyc + ((BYP != 0 && k == 0) ? 0 : 1);
      end
    end
    if (fire != '0) begin
      fi = oh2idx(fire); j = -1;
      foreach (uq[q]) if (j < 0 && uq[q].idx == fi) j = q;
      if (j >= 0) uq.delete(j);
    end
    exp_wbv = !kill_i && oq.size() > 0 && oq[0].cmpl && oq[0].rdy <= cyc;
    chk("wb_valid", 64'(wb_valid_o), 64'(exp_wbv));
    if (exp_wbv) begin
      chk("wb_we", 64'(wb_rf_we_o), 64'(oq[0].we));
      chk("wb_waddr", 64'(wb_rf_waddr_o), 64'(oq[0].waddr));
      chk("wb_wdata", 64'(wb_rf_wdata_o), 64'(oq[0].data));
      if (wb_ready_i) void'(oq.pop_front());
    end
    if (wb_valid_o && wb_ready_i) begin
      wb_log.push_back(wb_rf_wdata_o);
      last_wb_cyc = cyc;
    end
    if ((unit_valid_o & unit_ready_i) != '0) begin
      fi = oh2idx(unit_valid_o & unit_ready_i);
      uq.push_back('{idx: fi, res: f(unit_op_a_o, unit_op_b_o, fi)});
    end
    if (!kill_i && id_valid_i && exp_rdy) begin
      fi = oh2idx(id_unit_i);
      oq.push_back('{unit: id_unit_i, we: id_rf_we_i, waddr: id_rf_waddr_i,
                     data: (fi < 0) ? '0 : f(id_op_a_i, id_op_b_i, fi), cmpl: (fi < 0), rdy: cyc + 1});
    end
    if (kill_i) begin
      oq.delete();
      uq.delete();
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle();
    set_id(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  int c0;

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 64'(count_o), 64'(0));
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_wbv", 64'(wb_valid_o), 64'(0));
    chk("rst_rready", 64'(unit_rready_o), 64'(0));
    chk("rst_wdata", 64'({wb_rf_we_o, wb_rf_waddr_o, wb_rf_wdata_o}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    unit_ready_i = '1;
    wb_ready_i = 1'b1;

    // Single op to unit 1, result two cycles after issue
    c0 = cyc;
    set_id(1'b1, 4'b0010, 32'd5, 32'd7, 1'b1, 5'd3);
    step();
    idle();
    step();
    rv_en = 4'b0010;
    step();
    rv_en = '0;
    step();
    step();
    chk("t1_latency", 64'(last_wb_cyc), 64'(c0 + 2 + (1 - BYP)));
    chk("t1_wdata", 64'(wb_log[wb_log.size()-1]), 64'(12));
    chk("t1_count", 64'(count_o), 64'(0));

    // Slow unit 2 then fast unit 0: unit 0 must wait its turn
    wb_log.delete();
    set_id(1'b1, 4'b0100, 32'd100, 32'd1, 1'b1, 5'd8);
    step();
    set_id(1'b1, 4'b0001, 32'd3, 32'd4, 1'b1, 5'd9);
    step();
    idle();
    rv_en = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ooo_hold0", 64'(last_rr[0]), 64'(0));
    end
    rv_en = 4'b0101;
    for (int i = 0; i < 6; i++) step();
    rv_en = '0;
    chk("ooo_n", 64'(wb_log.size()), 64'(2));
    chk("ooo_first", 64'(wb_log[0]), 64'(32'h0200_0065));
    chk("ooo_second", 64'(wb_log[1]), 64'(7));

    // No-unit entry: no unit pulse, visible next cycle with zero data
    set_id(1'b1, 4'b0000, 32'd9, 32'd9, 1'b0, 5'd4);
    step();
    chk("nu_no_pulse", 64'(last_uv), 64'(0));
    idle();
    step();
    chk("nu_wbv", 64'(last_wbv), 64'(1));
    chk("nu_wdata", 64'(last_wdata), 64'(0));

    // Full: no bypass of the full check when WB frees a slot the same cycle
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 4'b0000, '0, '0, 1'b1, AW'(10 + i));
      step();
    end
    wb_ready_i = 1'b1;
    step();
    chk("full_block", 64'(last_ir), 64'(0));
    step();
    chk("full_accept", 64'(last_ir), 64'(1));
    idle();
    repeat (6) step();

    // Kill with three entries pending and a unit-1 result arriving
    wb_ready_i = 1'b0;
    set_id(1'b1, 4'b0000, '0, '0, 1'b1, 5'd1);
    step();
    set_id(1'b1, 4'b0010, 32'd1, 32'd2, 1'b1, 5'd2);
    step();
    set_id(1'b1, 4'b0010, 32'd3, 32'd4, 1'b1, 5'd3);
    step();
    idle();
    wb_ready_i = 1'b1;
    kill_i = 1'b1;
    rv_en = 4'b0010;
    step();
    chk("kill_wbv", 64'(last_wbv), 64'(0));
    chk("kill_ukill", 64'(last_uk), 64'(1));
    kill_i = 1'b0;
    rv_en = '0;
    stale_rv = 4'b0010;
    step();
    chk("kill_stale_rr", 64'(last_rr), 64'(0));
    stale_rv = '0;

    // Asynchronous reset in the middle of traffic
    set_id(1'b1, 4'b0010, 32'd6, 32'd6, 1'b1, 5'd5);
    step();
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rstmid_count", 64'(count_o), 64'(0));
    chk("rstmid_rr", 64'(unit_rready_o), 64'(0));
    chk("rstmid_wbv", 64'(wb_valid_o), 64'(0));
    oq.delete();
    uq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale_rv = 4'b0010;
    step();
    stale_rv = '0;

    // Random traffic
    rv_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      set_id($urandom_range(0, 9) < 7,
             ($urandom_range(0, 4) == 0) ? 4'b0000 : (4'b0001 << $urandom_range(0, 3)),
             $urandom(), $urandom(), 1'($urandom()), AW'($urandom()));
      unit_ready_i = NU'($urandom());
      wb_ready_i = $urandom_range(0, 3) != 0;
      halt_i = $urandom_range(0, 9) == 0;
      kill_i = $urandom_range(0, 49) == 0;
      step();
    end

    // Drain with a bounded cycle budget
    idle();
    halt_i = 1'b0;
    kill_i = 1'b0;
    wb_ready_i = 1'b1;
    for (int i = 0; i < 300 && oq.size() != 0; i++) step();
    chk("drain", 64'(oq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
